// File: rtl/sram_arbiter_if.sv
// Request/acknowledge and SRAM control bundle for sram_arbiter.
// slave modport: arbiter side. master modport: requesters and SRAM observer.
// ADDR_W/DATA_W must match the parameters of the attached sram_arbiter.
interface sram_arbiter_if #(
    parameter int unsigned ADDR_W = 11,
    parameter int unsigned DATA_W = 8
);
    logic              req0;
    logic              we0;
    logic [ADDR_W-1:0] addr0;
    logic [DATA_W-1:0] wdata0;
    logic              ack0;
    logic [DATA_W-1:0] rdata0;

    logic              req1;
    logic              we1;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata1;
    logic              ack1;
    logic [DATA_W-1:0] rdata1;

    logic              init_done;
    logic              sram_cs;
    logic              sram_oe;
    logic              sram_we;
    logic [ADDR_W-1:0] sram_addr;

    modport master (
        output req0, we0, addr0, wdata0,
        output req1, we1, addr1, wdata1,
        input  ack0, rdata0, ack1, rdata1,
        input  init_done, sram_cs, sram_oe, sram_we, sram_addr
    );

    modport slave (
        input  req0, we0, addr0, wdata0,
        input  req1, we1, addr1, wdata1,
        output ack0, rdata0, ack1, rdata1,
        output init_done, sram_cs, sram_oe, sram_we, sram_addr
    );
endinterface

// File: rtl/sram_arbiter.sv
// Two-port round-robin arbiter/sequencer for a single-port async-style SRAM.
// Write takes one WR cycle, read takes RD1 (address) + RD2 (sample); ack is registered.
// Optional macro SRAM_CLEAR_EN: after reset sweep CLR_VAL into every location
// before accepting requests.
module sram_arbiter #(
    parameter int unsigned         ADDR_W  = 11,
    parameter int unsigned         DATA_W  = 8,
    parameter logic [DATA_W-1:0]   CLR_VAL = '0
) (
    input  logic                clk,
    input  logic                reset,
    sram_arbiter_if.slave       bus,
    inout  wire  [DATA_W-1:0]   sram_data
);

`ifdef SRAM_CLEAR_EN
    typedef enum logic [2:0] {StIdle, StWr, StRd1, StRd2, StClr} state_t;
`else
    typedef enum logic [2:0] {StIdle, StWr, StRd1, StRd2} state_t;
`endif

    state_t            state_q, state_d;
    logic              last_q, last_d;      // 1: port 1 was granted last
    logic              sel_q, sel_d;        // port currently being served
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              ack0_q, ack0_d, ack1_q, ack1_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic              init_done_q, init_done_d;
`ifdef SRAM_CLEAR_EN
    logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
`endif

    logic              cs, oe, we;
    logic [ADDR_W-1:0] addr_out;
    logic              drive_en;
    logic [DATA_W-1:0] drive_val;
    logic              elig0, elig1, grant1;

    // A port that is being acked this cycle cannot be re-granted until the next IDLE cycle
    assign elig0  = bus.req0 && !ack0_q;
    assign elig1  = bus.req1 && !ack1_q;
    assign grant1 = elig1 && (!elig0 || !last_q);

    // Next-state, command latch and SRAM control decode
    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        sel_d       = sel_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        ack0_d      = 1'b0;
        ack1_d      = 1'b0;
        rdata0_d    = rdata0_q;
        rdata1_d    = rdata1_q;
`ifdef SRAM_CLEAR_EN
        init_done_d = init_done_q;
        clr_addr_d  = clr_addr_q;
`else
        init_done_d = 1'b1;
`endif
        cs          = 1'b0;
        oe          = 1'b0;
        we          = 1'b0;
        addr_out    = '0;
        drive_en    = 1'b0;
        drive_val   = wdata_q;

        case (state_q)
            StIdle: begin
                if (elig0 || elig1) begin
                    sel_d   = grant1;
                    last_d  = grant1;
                    we_d    = grant1 ? bus.we1    : bus.we0;
                    addr_d  = grant1 ? bus.addr1  : bus.addr0;
                    wdata_d = grant1 ? bus.wdata1 : bus.wdata0;
                    state_d = we_d ? StWr : StRd1;
                end
            end
            StWr: begin
                cs       = 1'b1;
                we       = 1'b1;
                addr_out = addr_q;
                drive_en = 1'b1;
                ack0_d   = !sel_q;
                ack1_d   = sel_q;
                state_d  = StIdle;
            end
            StRd1: begin
                cs       = 1'b1;
                oe       = 1'b1;
                addr_out = addr_q;
                state_d  = StRd2;
            end
            StRd2: begin
                cs       = 1'b1;
                oe       = 1'b1;
                addr_out = addr_q;
                if (sel_q) rdata1_d = sram_data;
                else       rdata0_d = sram_data;
                ack0_d   = !sel_q;
                ack1_d   = sel_q;
                state_d  = StIdle;
            end
`ifdef SRAM_CLEAR_EN
            StClr: begin
                cs         = 1'b1;
                we         = 1'b1;
                addr_out   = clr_addr_q;
                drive_en   = 1'b1;
                drive_val  = CLR_VAL;
                clr_addr_d = clr_addr_q + 1'b1;
                if (clr_addr_q == {ADDR_W{1'b1}}) begin
                    state_d     = StIdle;
                    init_done_d = 1'b1;
                end
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
`ifdef SRAM_CLEAR_EN
            state_q    <= StClr;
            clr_addr_q <= '0;
`else
            state_q    <= StIdle;
`endif
            last_q      <= 1'b1;
            sel_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= CLR_VAL;
            ack0_q      <= 1'b0;
            ack1_q      <= 1'b0;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
`ifdef SRAM_CLEAR_EN
            clr_addr_q  <= clr_addr_d;
`endif
            last_q      <= last_d;
            sel_q       <= sel_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            ack0_q      <= ack0_d;
            ack1_q      <= ack1_d;
            rdata0_q    <= rdata0_d;
            rdata1_q    <= rdata1_d;
            init_done_q <= init_done_d;
        end
    end

    assign sram_data     = drive_en ? drive_val : {DATA_W{1'bz}};
    assign bus.sram_cs   = cs;
    assign bus.sram_oe   = oe;
    assign bus.sram_we   = we;
    assign bus.sram_addr = addr_out;
    assign bus.ack0      = ack0_q;
    assign bus.ack1      = ack1_q;
    assign bus.rdata0    = rdata0_q;
    assign bus.rdata1    = rdata1_q;
    assign bus.init_done = init_done_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench for sram_arbiter: stimulus pushes expected acks, a negedge monitor pops them.
// Includes a behavioural SRAM (address registered at end of RD1, data driven in RD2).
module tb_sram_arbiter;
    localparam int unsigned ADDR_W = 11;
    localparam int unsigned DATA_W = 8;
`ifdef SRAM_CLEAR_EN
    localparam int          CLR_CYC = 2048;
    localparam logic [7:0]  RST_RD  = 8'h00;
`else
    localparam int          CLR_CYC = 0;
    localparam logic [7:0]  RST_RD  = 8'hA5;
`endif

    typedef struct {
        int         port;
        bit         rd;
        logic [7:0] data;
        int         cyc;
    } exp_t;

    logic clk;
    logic reset;
    wire  [DATA_W-1:0] sram_data;
    int   cyc;
    int   checks;
    int   failures;
    exp_t sb[$];

    sram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    sram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CLR_VAL(8'h00)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .sram_data (sram_data)
    );

    // Behavioural SRAM, preloaded with FF on the first clock
    logic [7:0] mem [0:2047];
    logic [7:0] mem_dout;
    logic       mem_en;
    always @(posedge clk) begin
        if (cyc == 0) begin
            for (int i = 0; i < 2048; i++) mem[i] <= 8'hFF;
            mem_en <= 1'b0;
        end else begin
            if (bus.sram_cs && bus.sram_we) mem[bus.sram_addr] <= sram_data;
            if (bus.sram_cs && bus.sram_oe && !bus.sram_we) begin
                mem_dout <= mem[bus.sram_addr];
                mem_en   <= 1'b1;
            end else begin
                mem_en   <= 1'b0;
            end
        end
    end
    assign sram_data = mem_en ? mem_dout : 8'hzz;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: protocol invariants and scoreboard pop on every ack
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            check("we_oe_exclusive", {31'd0, bus.sram_we && bus.sram_oe}, 0);
            if (bus.ack0 || bus.ack1) begin
                check("ack_both", {31'd0, bus.ack0 && bus.ack1}, 0);
                if (sb.size() == 0) begin
                    check("ack_unexpected", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("ack_port", {31'd0, bus.ack1}, e.port);
                    check("ack_cycle", cyc, e.cyc);
                    if (e.rd)
                        check("rdata", e.port == 1 ? bus.rdata1 : bus.rdata0, e.data);
                end
            end
        end
    end

    // One command on one port; grant expected at max(issue, ready)
    task automatic do_op(input int port, input bit we, input logic [10:0] addr,
                         input logic [7:0] wd, input logic [7:0] exp_rd,
                         input int lat, input int ready);
        int  issue, grant, exp_cyc, budget;
        bit  got, ack;
        @(negedge clk);
        issue   = cyc;
        grant   = (ready > issue) ? ready : issue;
        exp_cyc = grant + lat;
        budget  = exp_cyc - issue + 20;
        sb.push_back('{port: port, rd: !we, data: exp_rd, cyc: exp_cyc});
        if (port == 0) begin
            bus.we0 = we; bus.addr0 = addr; bus.wdata0 = wd; bus.req0 = 1'b1;
        end else begin
            bus.we1 = we; bus.addr1 = addr; bus.wdata1 = wd; bus.req1 = 1'b1;
        end
        got = 0;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge clk);
            if (we && cyc == grant + 1) begin
                check("wr_we",   {31'd0, bus.sram_we}, 1);
                check("wr_bus",  {24'd0, sram_data}, {24'd0, wd});
                check("wr_addr", {21'd0, bus.sram_addr}, {21'd0, addr});
            end
            if (we && cyc == grant + 2) check("wr_pulse_end", {31'd0, bus.sram_we}, 0);
            // Scramble held inputs after the grant; the latched command must win
            if (cyc == grant + 1) begin
                if (port == 0) begin bus.addr0 = ~addr; bus.wdata0 = ~wd; end
                else           begin bus.addr1 = ~addr; bus.wdata1 = ~wd; end
            end
            ack = (port == 0) ? bus.ack0 : bus.ack1;
            if (ack) begin
                got = 1;
                if (port == 0) bus.req0 = 1'b0; else bus.req1 = 1'b0;
            end
        end
        if (!got) begin
            check("ack_timeout", 0, 1);
            if (port == 0) bus.req0 = 1'b0; else bus.req1 = 1'b0;
        end
    endtask

    initial begin
        int n;
        int rel;
        bit seen;
        checks = 0; failures = 0; cyc = 0;
        reset = 1'b1;
        bus.req0 = 0; bus.we0 = 0; bus.addr0 = '0; bus.wdata0 = '0;
        bus.req1 = 0; bus.we1 = 0; bus.addr1 = '0; bus.wdata1 = '0;

        repeat (3) @(negedge clk);
        check("rst_ack0", {31'd0, bus.ack0}, 0);
        check("rst_ack1", {31'd0, bus.ack1}, 0);
        check("rst_rdata0", {24'd0, bus.rdata0}, 0);
        check("rst_rdata1", {24'd0, bus.rdata1}, 0);
        check("rst_init_done", {31'd0, bus.init_done}, 0);
        check("rst_oe", {31'd0, bus.sram_oe}, 0);
`ifndef SRAM_CLEAR_EN
        check("rst_cs", {31'd0, bus.sram_cs}, 0);
        check("rst_we", {31'd0, bus.sram_we}, 0);
        check("rst_addr", {21'd0, bus.sram_addr}, 0);
`endif
        reset = 1'b0;
        rel   = cyc;

`ifdef SRAM_CLEAR_EN
        seen = 0;
        fork
            begin
                for (int i = 0; i < 3000 && !seen; i++) begin
                    @(negedge clk);
                    if (bus.init_done) begin
                        seen = 1;
                        check("init_done_cycle", cyc - rel, 2048);
                    end
                end
                if (!seen) check("init_done_timeout", 0, 1);
            end
            begin
                repeat (4) @(negedge clk);
                do_op(0, 0, 11'h000, 8'h00, 8'h00, 3, rel + 2048);
            end
        join
        do_op(0, 0, 11'h400, 8'h00, 8'h00, 3, 0);
        do_op(1, 0, 11'h7FF, 8'h00, 8'h00, 3, 0);
`else
        @(negedge clk);
        check("init_done_after_reset", {31'd0, bus.init_done}, 1);
        seen = 0;
`endif

        // Both ports hold write requests: grants alternate 0,1,0,1 two cycles apart
        @(negedge clk);
        n = cyc;
        bus.we0 = 1; bus.addr0 = 11'h010; bus.wdata0 = 8'hAA;
        bus.we1 = 1; bus.addr1 = 11'h7FF; bus.wdata1 = 8'h55;
        bus.req0 = 1; bus.req1 = 1;
        sb.push_back('{port: 0, rd: 0, data: 8'h00, cyc: n + 2});
        sb.push_back('{port: 1, rd: 0, data: 8'h00, cyc: n + 4});
        sb.push_back('{port: 0, rd: 0, data: 8'h00, cyc: n + 6});
        sb.push_back('{port: 1, rd: 0, data: 8'h00, cyc: n + 8});
        repeat (6) @(negedge clk);
        bus.req0 = 0;
        repeat (2) @(negedge clk);
        bus.req1 = 0;

        // Port 0 write/read, then port 1 write/read at the top address
        do_op(0, 1, 11'h123, 8'hA5, 8'h00, 2, 0);
        do_op(0, 0, 11'h123, 8'h00, 8'hA5, 3, 0);
        do_op(0, 0, 11'h010, 8'h00, 8'hAA, 3, 0);
        do_op(1, 1, 11'h7FF, 8'h3C, 8'h00, 2, 0);
        do_op(1, 0, 11'h7FF, 8'h00, 8'h3C, 3, 0);
        check("rdata0_held", {24'd0, bus.rdata0}, 32'hAA);
        do_op(0, 0, 11'h123, 8'h00, 8'hA5, 3, 0);

        // Reset during RD1 aborts; held request is served after release
        @(negedge clk);
        n = cyc;
        bus.we0 = 0; bus.addr0 = 11'h123; bus.req0 = 1;
        @(negedge clk);
        check("in_rd1_oe", {31'd0, bus.sram_oe}, 1);
        reset = 1'b1;
        @(negedge clk);
        check("abort_ack0", {31'd0, bus.ack0}, 0);
        check("abort_oe", {31'd0, bus.sram_oe}, 0);
        check("abort_rdata0", {24'd0, bus.rdata0}, 0);
        check("abort_init_done", {31'd0, bus.init_done}, 0);
`ifndef SRAM_CLEAR_EN
        check("abort_cs", {31'd0, bus.sram_cs}, 0);
        check("abort_we", {31'd0, bus.sram_we}, 0);
        check("abort_addr", {21'd0, bus.sram_addr}, 0);
`endif
        reset = 1'b0;
        sb.push_back('{port: 0, rd: 1, data: RST_RD, cyc: n + 5 + CLR_CYC});
        seen = 0;
        for (int i = 0; i < CLR_CYC + 20 && !seen; i++) begin
            @(negedge clk);
            if (bus.ack0) begin
                seen = 1;
                bus.req0 = 0;
            end
        end
        if (!seen) begin
            check("reserve_timeout", 0, 1);
            bus.req0 = 0;
        end

        repeat (3) @(negedge clk);
        check("scoreboard_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
